prog_loader: RTL and testbench

- Upstream program-load stage for the Proc core.
- Receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words and writes them sequentially into Proc's instruction memory through Proc's a/d/we load port.
- After the last word it asserts exec, handing control to the processor.
- Replaces bench-driven memory preloading with a self-contained loader.

---
 rtl/proc_pkg.sv | 23 ++
 rtl/prog_loader_byte_to_word.sv | 50 +++++
 rtl/prog_loader.sv | 188 ++++++++++++++++++
 tb/tb_prog_loader.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// -----------------------------------------------------------------------------
// proc_pkg
//   Constants and types shared by the Proc program loader.
//   - ADDR_W / DATA_W : width of Proc's instruction-memory load port.
//   - loader_state_e  : encoding of the prog_loader control states.
// -----------------------------------------------------------------------------
package proc_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        WORD   = 3'd3,
        WRITE  = 3'd4,
        CKSUM  = 3'd5,
        DONE   = 3'd6,
        ERR    = 3'd7
    } loader_state_e;

endpackage

// File: rtl/prog_loader_byte_to_word.sv
// -----------------------------------------------------------------------------
// byte_to_word
//   Big-endian 4-byte assembler. Bytes shift in MSB first; on the 4th byte
//   word_valid pulses combinationally together with the complete word, so the
//   consumer can capture it on that same edge.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   clear      in   synchronous restart of the byte counter
//   byte_in    in   [7:0] incoming stream byte
//   byte_valid in   byte_in is consumed this cycle
//   word       out  [DATA_W-1:0] {three held bytes, byte_in}
//   word_valid out  byte_valid on the 4th byte of a word
// -----------------------------------------------------------------------------
module byte_to_word
    import proc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic [DATA_W-1:0] word,
    output logic              word_valid
);

    logic [23:0] shreg;
    logic [1:0]  cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (byte_valid) begin
            shreg <= {shreg[15:0], byte_in};
            cnt   <= cnt + 2'd1;  // wraps to 0 after the 4th byte
        end
    end

    // The first three bytes always overwrite all of shreg, so stale contents
    // after a clear never leak into a word.
    assign word       = {shreg, byte_in};
    assign word_valid = byte_valid && (cnt == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//   Program-load stage for the Proc core. Accepts a byte stream
//   (16-bit word count N, MSB first, then N big-endian 32-bit words), writes
//   the words to consecutive addresses from BASE_ADDR through Proc's a/d/we
//   port, then raises exec. A count that would run past DEPTH aborts with err.
//
// Optional feature (macro PROG_LOADER_CHECKSUM_EN):
//   After the words one extra byte is accepted and compared with the XOR of
//   all preceding stream bytes (length bytes included); match -> exec,
//   mismatch -> err. Required even when N = 0.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-low reset
//   start     in   one-cycle pulse; begins or restarts a load (wins over data)
//   in_data   in   [7:0] stream byte
//   in_valid  in   in_data valid
//   in_ready  out  byte accepted this cycle when in_valid is also high
//   mem_a     out  [ADDR_W-1:0] Proc a
//   mem_d     out  [DATA_W-1:0] Proc d (DATA_W must be 32)
//   mem_we    out  Proc we, one cycle per word
//   exec      out  Proc exec, held until start/reset
//   busy      out  load in progress
//   err       out  load aborted, held until start/reset
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int ADDR_W    = proc_pkg::ADDR_W,
    parameter int DATA_W    = proc_pkg::DATA_W,
    parameter int DEPTH     = 512,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    output logic              mem_we,
    output logic              exec,
    output logic              busy,
    output logic              err
);

    import proc_pkg::*;

    // Plain vector state with named constants keeps the encoding visible to
    // older tooling that does not understand enum-typed ports or probes.
    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_LEN_HI = LEN_HI;
    localparam logic [2:0] S_LEN_LO = LEN_LO;
    localparam logic [2:0] S_WORD   = WORD;
    localparam logic [2:0] S_WRITE  = WRITE;
    localparam logic [2:0] S_DONE   = DONE;
    localparam logic [2:0] S_ERR    = ERR;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CKSUM  = CKSUM;
    // Both "load finished" paths must pass through the checksum byte first.
    localparam logic [2:0] S_FINISH = S_CKSUM;
`else
    localparam logic [2:0] S_FINISH = S_DONE;
`endif

    // Words that fit between BASE_ADDR and the top of memory.
    localparam int CAPACITY = DEPTH - BASE_ADDR;

    logic [2:0]        state;
    logic [15:0]       word_cnt;   // N from the length header
    logic [15:0]       word_idx;   // words written so far
    logic [15:0]       idx_inc;
    logic [15:0]       len_next;
    logic              len_too_big;
    logic              xfer;
    logic [DATA_W-1:0] asm_word;
    logic              asm_valid;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    // NOTE: every output of a combinational block gets a default first, so
    // no path through it leaves a value unassigned (which would infer a latch).
    always_comb begin
        in_ready = 1'b0;
        if (!start) begin
            unique case (state)
                S_LEN_HI, S_LEN_LO, S_WORD: in_ready = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                S_CKSUM:                    in_ready = 1'b1;
`endif
                default:                    in_ready = 1'b0;
            endcase
        end
    end

    assign xfer     = in_valid && in_ready;
    assign mem_we   = (state == S_WRITE);
    assign exec     = (state == S_DONE);
    assign err      = (state == S_ERR);
    assign busy     = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                      (state == S_WORD)   || (state == S_WRITE);

    assign idx_inc     = word_idx + 16'd1;
    assign len_next    = {word_cnt[15:8], in_data};
    assign len_too_big = int'({16'd0, len_next}) > CAPACITY;

    byte_to_word u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (start),
        .byte_in    (in_data),
        .byte_valid (xfer && (state == S_WORD)),
        .word       (asm_word),
        .word_valid (asm_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            word_cnt <= '0;
            word_idx <= '0;
            mem_a    <= '0;
            mem_d    <= '0;
        end else if (start) begin
            // Restart from anywhere; mem_a/mem_d keep their last value.
            state    <= S_LEN_HI;
            word_cnt <= '0;
            word_idx <= '0;
        end else begin
            unique case (state)
                S_LEN_HI: begin
                    if (xfer) begin
                        word_cnt[15:8] <= in_data;
                        state          <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        word_cnt[7:0] <= in_data;
                        if (len_next == 16'd0) begin
                            state <= S_FINISH;
                        end else if (len_too_big) begin
                            state <= S_ERR;
                        end else begin
                            state <= S_WORD;
                        end
                    end
                end
                S_WORD: begin
                    // Port registers load here so they are stable for the
                    // whole WRITE cycle and hold afterwards.
                    if (asm_valid) begin
                        mem_a <= ADDR_W'(BASE_ADDR + int'(word_idx));
                        mem_d <= asm_word;
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    word_idx <= idx_inc;
                    state    <= (idx_inc == word_cnt) ? S_FINISH : S_WORD;
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                S_CKSUM: begin
                    if (xfer) begin
                        state <= (in_data == csum) ? S_DONE : S_ERR;
                    end
                end
`endif
                default: ;  // IDLE, DONE, ERR wait for start
            endcase
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    // Running XOR of every accepted byte since the last start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum <= '0;
        end else if (start) begin
            csum <= '0;
        end else if (xfer) begin
            csum <= csum ^ in_data;
        end
    end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//   Self-checking bench for prog_loader (default parameters). A stream-level
//   model turns (N, word list) into the byte stream, the expected write list
//   and the final exec/err outcome; a negedge monitor compares every write
//   and the exec timing against it. Honours PROG_LOADER_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module tb_prog_loader;

    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [8:0]  mem_a;
    logic [31:0] mem_d;
    logic        mem_we;
    logic        exec;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    prog_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_a    (mem_a),
        .mem_d    (mem_d),
        .mem_we   (mem_we),
        .exec     (exec),
        .busy     (busy),
        .err      (err)
    );

    typedef struct packed {
        logic [8:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         seen_q[$];
    logic [31:0] wq[$];
    logic [7:0]  stream[$];
    int          exp_n;
    bit          exp_exec;
    bit          exp_err;
    bit          exec_due = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic wr_t get_seen(input int i);
        if (i < seen_q.size()) return seen_q[i];
        return '0;
    endfunction

    // Stream-level model: builds bytes, expected writes and final outcome.
    task automatic make_stream(input int n);
        logic [15:0] n16;
        logic [7:0]  x;
        n16 = n[15:0];
        stream.delete();
        exp_q.delete();
        seen_q.delete();
        stream.push_back(n16[15:8]);
        stream.push_back(n16[7:0]);
        foreach (wq[i])
            for (int k = 3; k >= 0; k--)
                stream.push_back(wq[i][8*k +: 8]);
        exp_n    = n;
        exp_err  = (n > DEPTH);
        exp_exec = !exp_err;
        if (!exp_err)
            foreach (wq[i]) exp_q.push_back({9'(i), wq[i]});
`ifdef PROG_LOADER_CHECKSUM_EN
        if (!exp_err) begin
            x = 8'h00;
            foreach (stream[i]) x ^= stream[i];
            stream.push_back(x);
        end
`endif
    endtask

    // Called near a negedge; returns at the negedge after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit rdy;
        int n;
        if (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        forever begin
            #1 rdy = in_ready;
            @(posedge clk);
            @(negedge clk);
            if (rdy) break;
            n++;
            if (n > 20) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout: got no ready for byte %0h", b);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_stream(input bit gap, input int limit);
        for (int i = 0; i < stream.size() && i < limit; i++) begin
            send_byte(stream[i], gap);
            if (!exp_err && i >= 2 && i < 2 + 4*exp_n && ((i - 2) % 4) == 3)
                check("we_after_4th_byte", mem_we, 1);
            if (i == 1) begin
                if (exp_err) begin
                    check("ovf_err", err, 1);
                    check("ovf_ready", in_ready, 0);
                    check("ovf_exec", exec, 0);
                end else if (exp_n == 0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    check("zero_wait_cksum", in_ready, 1);
                    check("zero_exec_early", exec, 0);
`else
                    check("zero_exec_next", exec, 1);
`endif
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            if (i >= 2 && i == stream.size() - 1)
                check("exec_after_cksum", exec, exp_exec);
`endif
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_check(input string tag);
        repeat (2) @(negedge clk);
        check({tag, "_exec"}, exec, exp_exec);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ready"}, in_ready, 0);
        check({tag, "_writes_left"}, exp_q.size(), 0);
    endtask

    // Compare process: every write against the model, exec timing, exclusivity.
    always @(negedge clk) begin
        wr_t e;
        if (!rst) begin
            exec_due = 1'b0;
        end else begin
            if (exec_due) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                check("cksum_state_ready", in_ready, 1);
                check("cksum_state_exec", exec, 0);
`else
                check("exec_after_last_write", exec, 1);
`endif
                exec_due = 1'b0;
            end
            if (mem_we) begin
                check("write_ready_low", in_ready, 0);
                check("write_busy", busy, 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", mem_we, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", mem_a, e.a);
                    check("write_data", mem_d, e.d);
                    seen_q.push_back({mem_a, mem_d});
                    if (exp_q.size() == 0 && exp_exec) exec_due = 1'b1;
                end
            end
            check("exec_err_excl", exec & err, 0);
            check("busy_vs_final", busy & (exec | err), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check("rst_mem_a", mem_a, 0);
        check("rst_mem_d", mem_d, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_exec", exec, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b1;

        // Basic load; pin the model with hand-computed stream bytes
        wq = '{32'hFC170000, 32'h35EF000D};
        make_stream(2);
        check("model_len", {stream[0], stream[1]}, 16'h0002);
        check("model_word0_lsb", stream[5], 8'h00);
`ifdef PROG_LOADER_CHECKSUM_EN
        check("model_cksum", stream[10], 8'h3E);
`endif
        do_start();
        check("start_busy", busy, 1);
        send_stream(0, 1000);
        finish_check("basic");
        check("basic_w0", get_seen(0), {9'd0, 32'hFC170000});
        check("basic_w1", get_seen(1), {9'd1, 32'h35EF000D});

        // Same stream, in_valid toggling
        make_stream(2);
        do_start();
        send_stream(1, 1000);
        finish_check("gaps");
        check("gaps_w0", get_seen(0), {9'd0, 32'hFC170000});
        check("gaps_w1", get_seen(1), {9'd1, 32'h35EF000D});
        check("gaps_count", seen_q.size(), 2);

        // Zero length
        wq.delete();
        make_stream(0);
        do_start();
        send_stream(0, 1000);
        finish_check("zero");
        check("zero_no_writes", seen_q.size(), 0);

        // Overflow: N = 513
        make_stream(513);
        do_start();
        send_stream(0, 1000);
        finish_check("ovf");
        check("ovf_no_writes", seen_q.size(), 0);

        // Restart mid-load with start and in_valid together
        wq.delete();
        make_stream(3);
        exp_q.delete();
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hCC;
        #1 check("restart_ready_forced", in_ready, 0);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("restart_busy", busy, 1);
        check("restart_len_hi_ready", in_ready, 1);
        wq = '{32'h11223344};
        make_stream(1);
        send_stream(0, 1000);
        finish_check("restart");
        check("restart_w0", get_seen(0), {9'd0, 32'h11223344});

        // Reset asserted during a WRITE cycle
        wq = '{32'hDEADBEEF};
        make_stream(1);
        do_start();
        send_stream(0, 6);
        #1 rst = 1'b0;
        #1;
        check("arst_we", mem_we, 0);
        check("arst_busy", busy, 0);
        check("arst_mem_a", mem_a, 0);
        check("arst_mem_d", mem_d, 0);
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("arst_idle_ready", in_ready, 0);
        check("arst_idle_busy", busy, 0);
        check("arst_idle_exec", exec, 0);
        check("arst_seen", get_seen(0), {9'd0, 32'hDEADBEEF});

`ifdef PROG_LOADER_CHECKSUM_EN
        // Wrong checksum byte
        wq = '{32'hFC170000, 32'h35EF000D};
        make_stream(2);
        stream[stream.size() - 1] = stream[stream.size() - 1] ^ 8'h01;
        exp_exec = 1'b0;
        exp_err  = 1'b1;
        do_start();
        send_stream(0, 1000);
        finish_check("badcksum");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
